axis_traffic_gen: RTL and testbench
===================================

Name: axis_traffic_gen

Overview:
Parametrised AXI-Stream traffic generator and sink for NoC bring-up. It is the successor to the single-beat random-number source.
- Master side: emits multi-beat packets with LFSR payload, configurable length and count, and a selectable destination policy (fixed, round-robin, random).
- Master side obeys full AXIS backpressure.
- Slave side: always-ready sink that counts received beats and packets.
- Sits at a NoC endpoint, one instance per router port.

Parameters:
TDATAW, 32, AXIS data width; must be >= LFSR_W
TDESTW, 4, AXIS TDEST width
TIDW, 2, AXIS TID width
LFSR_W, 16, payload LFSR width
LFSR_SEED, 16'hACE1, LFSR value loaded on START; must be nonzero
LEN_W, 8, width of packet-length config
NUM_DEST, 4, number of destinations; power of two, <= 2**TDESTW
SRC_ID, 0, constant driven on AXIS_M_TID

Ports:
CLK  in  1  clock
RST_N  in  1  reset
START  in  1  pulse; begin a run, sampled only in IDLE
STOP  in  1  pulse; end run after the current packet completes
CFG_NUM_PKTS  in  16  packets per run; 0 = continuous until STOP
CFG_PKT_LEN  in  LEN_W  beats per packet; 0 treated as 1
CFG_DEST_MODE  in  2  00 fixed, 01 round-robin, 10 random, 11 = fixed
CFG_FIXED_DEST  in  TDESTW  destination used in fixed mode
BUSY  out  1  high from the cycle after START until the final beat is accepted
DONE  out  1  one-cycle pulse after the final beat is accepted
TX_PKT_CNT  out  16  packets sent in current/last run
RX_BEAT_CNT  out  16  beats accepted on slave side
RX_PKT_CNT  out  16  TLAST beats accepted on slave side
AXIS_S_TVALID/TREADY/TDATA/TLAST/TID/TDEST  slave AXIS, widths per params
AXIS_M_TVALID/TREADY/TDATA/TLAST/TID/TDEST  master AXIS, widths per params

Behaviour:
- Clock CLK; reset RST_N, asynchronous, active-low. All outputs are registered.
- Reset values: TVALID 0, TLAST 0, TDATA 0, TDEST 0, BUSY 0, DONE 0, all counters 0, AXIS_S_TREADY 0, FSM IDLE.
- AXIS_M_TID is the constant SRC_ID.
- FSM states: IDLE, SEND, FINISH.
  - IDLE: on START, latch all CFG_* inputs, load LFSR_SEED, clear TX_PKT_CNT, set beat index 0, go to SEND.
  - SEND: TVALID = 1. A beat is accepted when TVALID && TREADY. On the TLAST beat, TX_PKT_CNT increments.
  - SEND exits to FINISH when the TLAST beat is accepted and either the packet count reaches a nonzero CFG_NUM_PKTS or a STOP is pending.
  - FINISH: lasts one cycle with DONE = 1 and BUSY = 0, then returns to IDLE.
- Latency: START in cycle N gives TVALID = 1 with the first beat in cycle N+1.
- Holding rule: while TVALID && !TREADY, TDATA, TDEST and TLAST hold stable. TVALID never drops mid-packet.
- Payload:
  - TDATA = zero-extended LFSR state.
  - Galois right-shift LFSR; taps 16'hB400 for LFSR_W = 16.
  - Advances only on an accepted beat. The first beat carries the seed.
- TLAST is 1 on beat index max(CFG_PKT_LEN,1)-1. The beat index wraps to 0 after TLAST is accepted.
- TDEST is latched at the first beat of each packet and held constant for the whole packet.
  - Fixed: CFG_FIXED_DEST.
  - Round-robin: counter 0..NUM_DEST-1, reset to 0 at START, incremented per packet, wraps to 0.
  - Random: LFSR[log2(NUM_DEST)-1:0] at the packet's first beat.
- START while not in IDLE is ignored.
- STOP:
  - Sets a sticky pending flag, honoured at the next TLAST acceptance.
  - STOP in IDLE is ignored.
  - STOP coincident with a TLAST acceptance ends the run at that beat.
- TX_PKT_CNT wraps at 2**16. In continuous mode the run ends only on STOP.
- Sink side:
  - AXIS_S_TREADY goes to 1 on the first clock after reset and stays 1.
  - RX_BEAT_CNT increments on each TVALID && TREADY.
  - RX_PKT_CNT increments on each accepted TLAST.
  - Both counters wrap at 2**16 and are not cleared by START.
- Reset mid-packet aborts immediately: TVALID 0 and all state as at reset. No partial packet completes.

Decomposition:
- Package traffic_pkg:
  - dest_mode_e enum (DEST_FIXED, DEST_RR, DEST_RAND)
  - state_e enum (IDLE, SEND, FINISH)
  - LFSR tap constant per width
- Sub-module lfsr_ce: LFSR with clock-enable and synchronous seed-load; ports CLK, RST_N, LOAD, SEED, EN, O_DATA.

Test Plan:
- Always-ready sink, CFG_NUM_PKTS = 2, CFG_PKT_LEN = 3, fixed dest 4'h2, START pulse.
  - 6 beats on back-to-back cycles starting N+1.
  - TDATA 0x0000ACE1, 0x0000E270, 0x00007138, ...
  - TLAST on beats 3 and 6; TDEST = 2 throughout.
  - DONE pulses once; TX_PKT_CNT = 2.
- Backpressure: TREADY low for 5 cycles at beat 2.
  - TDATA, TLAST and TDEST stay stable while stalled.
  - The LFSR does not advance during the stall.
  - Sequence is identical to the first test.
- Round-robin, CFG_NUM_PKTS = 6, CFG_PKT_LEN = 1 -> TDEST sequence 0, 1, 2, 3, 0, 1; every beat has TLAST = 1.
- Continuous mode (CFG_NUM_PKTS = 0), CFG_PKT_LEN = 4; STOP at beat 2 of packet 3 -> packet 3 completes (4 beats), then DONE; TX_PKT_CNT = 3.
- Loopback master to slave, 5 packets of length 0 -> treated as length 1; RX_BEAT_CNT = 5, RX_PKT_CNT = 5. A second START while BUSY is ignored.
- Assert RST_N low mid-packet -> all outputs return to reset values asynchronously. A new START after reset gives a clean first beat 0x0000ACE1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and LFSR helpers for the AXI-Stream traffic generator.
package traffic_pkg;

  typedef enum logic [1:0] {
    DEST_FIXED = 2'b00,
    DEST_RR    = 2'b01,
    DEST_RAND  = 2'b10
  } dest_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int unsigned LFSR_MAX_W = 32;

  // Galois right-shift tap masks for the supported LFSR widths.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] s,
                                                      input logic [LFSR_MAX_W-1:0] taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_ce.sv
// Galois LFSR with synchronous seed load and clock enable.
module lfsr_ce
  import traffic_pkg::*;
#(
  parameter int unsigned     W    = 16,
  parameter logic [W-1:0]    TAPS = W'(lfsr_taps(W))
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LOAD,
  input  logic [W-1:0] SEED,
  input  logic         EN,
  output logic [W-1:0] O_DATA
);

  logic [W-1:0] state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    state_q <= '0;
    else if (LOAD) state_q <= SEED;
    else if (EN)   state_q <= W'(lfsr_step(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));
  end

  assign O_DATA = state_q;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator (LFSR payload, selectable TDEST policy) plus an always-ready counting sink.
module axis_traffic_gen
  import traffic_pkg::*;
#(
  parameter int unsigned        TDATAW    = 32,
  parameter int unsigned        TDESTW    = 4,
  parameter int unsigned        TIDW      = 2,
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
  parameter int unsigned        LEN_W     = 8,
  parameter int unsigned        NUM_DEST  = 4,
  parameter logic [TIDW-1:0]    SRC_ID    = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STOP,
  input  logic [15:0]       CFG_NUM_PKTS,
  input  logic [LEN_W-1:0]  CFG_PKT_LEN,
  input  logic [1:0]        CFG_DEST_MODE,
  input  logic [TDESTW-1:0] CFG_FIXED_DEST,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       TX_PKT_CNT,
  output logic [15:0]       RX_BEAT_CNT,
  output logic [15:0]       RX_PKT_CNT,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  localparam logic [1:0]        ST_IDLE   = IDLE;
  localparam logic [1:0]        ST_SEND   = SEND;
  localparam logic [1:0]        ST_FINISH = FINISH;
  localparam logic [TDESTW-1:0] DEST_MASK = TDESTW'(NUM_DEST - 1);

  logic [1:0]        state_q, state_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic              busy_q, busy_d, done_q, done_d, stop_q, stop_d;
  logic [TDESTW-1:0] tdest_q, tdest_d, rr_q, rr_d, rr_nxt;
  logic [15:0]       tx_cnt_q, tx_cnt_d, tx_inc;
  logic [LEN_W-1:0]  beat_q, beat_d, beat_inc, last_idx;
  logic [15:0]       cfg_num_q, cfg_num_d;
  logic [LEN_W-1:0]  cfg_len_q, cfg_len_d;
  logic [1:0]        cfg_mode_q, cfg_mode_d;
  logic [TDESTW-1:0] cfg_fdest_q, cfg_fdest_d;
  logic              s_tready_q;
  logic [15:0]       rx_beat_q, rx_pkt_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic              lfsr_load, lfsr_en, accept;
  logic              unused_s;

  lfsr_ce #(.W(LFSR_W)) u_lfsr (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .LOAD   (lfsr_load),
    .SEED   (LFSR_SEED),
    .EN     (lfsr_en),
    .O_DATA (lfsr_q)
  );

  function automatic logic [TDESTW-1:0] pick_dest(input logic [1:0]        mode,
                                                  input logic [TDESTW-1:0] fixed,
                                                  input logic [TDESTW-1:0] rr,
                                                  input logic [LFSR_W-1:0] rnd);
    case (mode)
      DEST_RR:   return rr;
      DEST_RAND: return TDESTW'(rnd) & DEST_MASK;
      default:   return fixed;
    endcase
  endfunction

  // Value the LFSR takes after the current beat is accepted, i.e. the next beat's payload.
  assign lfsr_nxt = LFSR_W'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(lfsr_taps(LFSR_W))));
  assign accept   = tvalid_q & AXIS_M_TREADY;
  assign tx_inc   = tx_cnt_q + 16'd1;
  assign beat_inc = beat_q + LEN_W'(1);
  assign last_idx = (cfg_len_q == '0) ? '0 : cfg_len_q - LEN_W'(1);
  assign rr_nxt   = (rr_q + TDESTW'(1)) & DEST_MASK;

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdest_d     = tdest_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stop_d      = stop_q;
    rr_d        = rr_q;
    tx_cnt_d    = tx_cnt_q;
    beat_d      = beat_q;
    cfg_num_d   = cfg_num_q;
    cfg_len_d   = cfg_len_q;
    cfg_mode_d  = cfg_mode_q;
    cfg_fdest_d = cfg_fdest_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_SEND;
          cfg_num_d   = CFG_NUM_PKTS;
          cfg_len_d   = CFG_PKT_LEN;
          cfg_mode_d  = CFG_DEST_MODE;
          cfg_fdest_d = CFG_FIXED_DEST;
          lfsr_load   = 1'b1;
          tvalid_d    = 1'b1;
          busy_d      = 1'b1;
          stop_d      = 1'b0;
          tx_cnt_d    = '0;
          beat_d      = '0;
          rr_d        = '0;
          tlast_d     = (CFG_PKT_LEN <= LEN_W'(1));
          tdest_d     = pick_dest(CFG_DEST_MODE, CFG_FIXED_DEST, '0, LFSR_SEED);
        end
      end
      ST_SEND: begin
        stop_d = stop_q | STOP;
        if (accept) begin
          lfsr_en = 1'b1;
          if (tlast_q) begin
            tx_cnt_d = tx_inc;
            if (((cfg_num_q != '0) && (tx_inc == cfg_num_q)) || stop_q || STOP) begin
              state_d  = ST_FINISH;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              stop_d   = 1'b0;
            end else begin
              beat_d  = '0;
              rr_d    = rr_nxt;
              tlast_d = (last_idx == '0);
              tdest_d = pick_dest(cfg_mode_q, cfg_fdest_q, rr_nxt, lfsr_nxt);
            end
          end else begin
            beat_d  = beat_inc;
            tlast_d = (beat_inc == last_idx);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdest_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      rr_q        <= '0;
      tx_cnt_q    <= '0;
      beat_q      <= '0;
      cfg_num_q   <= '0;
      cfg_len_q   <= '0;
      cfg_mode_q  <= '0;
      cfg_fdest_q <= '0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdest_q     <= tdest_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stop_q      <= stop_d;
      rr_q        <= rr_d;
      tx_cnt_q    <= tx_cnt_d;
      beat_q      <= beat_d;
      cfg_num_q   <= cfg_num_d;
      cfg_len_q   <= cfg_len_d;
      cfg_mode_q  <= cfg_mode_d;
      cfg_fdest_q <= cfg_fdest_d;
    end
  end

  // Sink: ready from the first clock after reset, counts beats and packets.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_tready_q <= 1'b0;
      rx_beat_q  <= '0;
      rx_pkt_q   <= '0;
    end else begin
      s_tready_q <= 1'b1;
      if (AXIS_S_TVALID && s_tready_q) begin
        rx_beat_q <= rx_beat_q + 16'd1;
        if (AXIS_S_TLAST) rx_pkt_q <= rx_pkt_q + 16'd1;
      end
    end
  end

  assign unused_s = ^{AXIS_S_TDATA, AXIS_S_TID, AXIS_S_TDEST};

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign TX_PKT_CNT    = tx_cnt_q;
  assign RX_BEAT_CNT   = rx_beat_q;
  assign RX_PKT_CNT    = rx_pkt_q;
  assign AXIS_S_TREADY = s_tready_q;
  assign AXIS_M_TVALID = tvalid_q;
  assign AXIS_M_TDATA  = TDATAW'(lfsr_q);
  assign AXIS_M_TLAST  = tlast_q;
  assign AXIS_M_TID    = SRC_ID;
  assign AXIS_M_TDEST  = tdest_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed scoreboard bench for axis_traffic_gen; master looped back into the sink.
module tb_axis_traffic_gen;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start, stop;
  logic [15:0] cfg_num;
  logic [7:0]  cfg_len;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_fdest;
  logic        busy, done;
  logic [15:0] tx_pkt_cnt, rx_beat_cnt, rx_pkt_cnt;
  logic        s_tvalid, s_tready;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [1:0]  m_tid;
  logic [3:0]  m_tdest;

  always #5 CLK = ~CLK;

  assign s_tvalid = m_tvalid & m_tready;

  axis_traffic_gen #(
    .TDATAW(32), .TDESTW(4), .TIDW(2), .LFSR_W(16), .LFSR_SEED(16'hACE1),
    .LEN_W(8), .NUM_DEST(4), .SRC_ID(2'd0)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .START          (start),
    .STOP           (stop),
    .CFG_NUM_PKTS   (cfg_num),
    .CFG_PKT_LEN    (cfg_len),
    .CFG_DEST_MODE  (cfg_mode),
    .CFG_FIXED_DEST (cfg_fdest),
    .BUSY           (busy),
    .DONE           (done),
    .TX_PKT_CNT     (tx_pkt_cnt),
    .RX_BEAT_CNT    (rx_beat_cnt),
    .RX_PKT_CNT     (rx_pkt_cnt),
    .AXIS_S_TVALID  (s_tvalid),
    .AXIS_S_TREADY  (s_tready),
    .AXIS_S_TDATA   (m_tdata),
    .AXIS_S_TLAST   (m_tlast),
    .AXIS_S_TID     (m_tid),
    .AXIS_S_TDEST   (m_tdest),
    .AXIS_M_TVALID  (m_tvalid),
    .AXIS_M_TREADY  (m_tready),
    .AXIS_M_TDATA   (m_tdata),
    .AXIS_M_TLAST   (m_tlast),
    .AXIS_M_TID     (m_tid),
    .AXIS_M_TDEST   (m_tdest)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  beat_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int done_seen = 0;
  int acc_cnt = 0;
  int exp_rx_beats = 0;
  int exp_rx_pkts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Push the expected beats of one run; every pushed beat is also expected at the sink.
  task automatic push_run(input int npk, input int len, input logic [1:0] mode, input logic [3:0] fd);
    logic [15:0] s;
    int          rr;
    int          l;
    logic [3:0]  d;
    beat_t       bt;
    s  = 16'hACE1;
    rr = 0;
    l  = (len == 0) ? 1 : len;
    for (int p = 0; p < npk; p++) begin
      case (mode)
        2'b01:   d = 4'(rr);
        2'b10:   d = {2'b00, s[1:0]};
        default: d = fd;
      endcase
      for (int b = 0; b < l; b++) begin
        bt.data = {16'h0000, s};
        bt.last = (b == l - 1);
        bt.dest = d;
        sb.push_back(bt);
        s = model_next(s);
      end
      rr = (rr + 1) % 4;
      exp_rx_pkts++;
      exp_rx_beats += l;
    end
  endtask

  // Sample the beat presented for the coming edge, then advance to the next falling edge.
  task automatic step();
    beat_t f;
    if (m_tvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(m_tdata), 64'hDEAD);
      end else begin
        f = sb[0];
        chk("tdata", 64'(m_tdata), 64'(f.data));
        chk("tlast", 64'(m_tlast), 64'(f.last));
        chk("tdest", 64'(m_tdest), 64'(f.dest));
        if (m_tready) begin
          void'(sb.pop_front());
          acc_cnt++;
        end
      end
    end
    if (done === 1'b1) done_seen++;
    @(negedge CLK);
  endtask

  task automatic start_run(input logic [15:0] n, input logic [7:0] len,
                           input logic [1:0] mode, input logic [3:0] fd);
    cfg_num   = n;
    cfg_len   = len;
    cfg_mode  = mode;
    cfg_fdest = fd;
    start     = 1'b1;
    step();
    start     = 1'b0;
    chk("start_latency_tvalid", 64'(m_tvalid), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int exp_tx, output int ncyc);
    int d0;
    d0   = done_seen;
    ncyc = 0;
    while (done_seen == d0 && ncyc < 300) begin
      step();
      ncyc++;
    end
    chk("done_seen", 64'(done_seen != d0), 64'd1);
    step();
    step();
    chk("done_once", 64'(done_seen - d0), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("tvalid_after", 64'(m_tvalid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(exp_tx));
    chk("rx_beat_cnt", 64'(rx_beat_cnt), 64'(exp_rx_beats));
    chk("rx_pkt_cnt", 64'(rx_pkt_cnt), 64'(exp_rx_pkts));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a0;
    int guard;
    RST_N     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    m_tready  = 1'b1;
    cfg_num   = '0;
    cfg_len   = '0;
    cfg_mode  = '0;
    cfg_fdest = '0;
    #2;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdest", 64'(m_tdest), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_counters", 64'({tx_pkt_cnt, rx_beat_cnt, rx_pkt_cnt}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("s_tready_up", 64'(s_tready), 64'd1);
    chk("tid_const", 64'(m_tid), 64'd0);

    // STOP in IDLE must not cut the following run short.
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    // Two 3-beat packets, fixed dest, always ready.
    push_run(2, 3, 2'b00, 4'h2);
    start_run(16'd2, 8'd3, 2'b00, 4'h2);
    wait_done(2, n);
    chk("b2b_cycles", 64'(n), 64'd7);

    // Same run with a 5-cycle stall on beat 2.
    push_run(2, 3, 2'b00, 4'h2);
    start_run(16'd2, 8'd3, 2'b00, 4'h2);
    step();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    m_tready = 1'b1;
    wait_done(2, n);

    // Round-robin, single-beat packets.
    push_run(6, 1, 2'b01, 4'h0);
    start_run(16'd6, 8'd1, 2'b01, 4'h0);
    wait_done(6, n);

    // Continuous mode, STOP during beat 2 of packet 3.
    push_run(3, 4, 2'b00, 4'h5);
    start_run(16'd0, 8'd4, 2'b00, 4'h5);
    a0 = acc_cnt;
    guard = 0;
    while (acc_cnt - a0 < 9 && guard < 100) begin
      step();
      guard++;
    end
    chk("stop_reach", 64'(acc_cnt - a0), 64'd9);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(3, n);

    // Random destination policy.
    push_run(3, 2, 2'b10, 4'h0);
    start_run(16'd3, 8'd2, 2'b10, 4'h0);
    wait_done(3, n);

    // Zero-length packets; START with a different config mid-run is ignored.
    push_run(5, 0, 2'b00, 4'h7);
    start_run(16'd5, 8'd0, 2'b00, 4'h7);
    step();
    cfg_len = 8'd3;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done(5, n);

    // Reset in the middle of a packet.
    push_run(2, 4, 2'b00, 4'h1);
    start_run(16'd2, 8'd4, 2'b00, 4'h1);
    step();
    step();
    RST_N = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_tdata", 64'(m_tdata), 64'd0);
    chk("midrst_tlast", 64'(m_tlast), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_counters", 64'({tx_pkt_cnt, rx_beat_cnt, rx_pkt_cnt}), 64'd0);
    sb.delete();
    exp_rx_beats = 0;
    exp_rx_pkts  = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("midrst_tvalid_held", 64'(m_tvalid), 64'd0);
    push_run(1, 1, 2'b00, 4'h0);
    start_run(16'd1, 8'd1, 2'b00, 4'h0);
    chk("post_rst_tdata", 64'(m_tdata), 64'h0000_ACE1);
    wait_done(1, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
